ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch front end; it is the consumer of the core's PC write/IRQ interface.
- Owns the fetch address and issues in-order requests to instruction memory over a valid/ready request channel with a fixed-latency-free response channel.
- Buffers returned words in a small prefetch queue and hands {instruction, pc} to decode with valid/ready.
- Accepts branch/PC-write redirects and IRQ entry, flushes the queue and discards stale in-flight responses.

Parameters:
- DEPTH, 2, prefetch queue entries; also the cap on queued + outstanding requests (power of 2, ≥2).
- RESET_VEC, 32'h0000_0000, fetch address after reset.
- IRQ_VEC, 32'h0000_0004, fetch address on IRQ entry.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  pipeline enable; low = no issue, no pop, no redirect taken
- i_redirect_en  in  1  PC write request (branch or PC-destination write)
- i_redirect_pc  in  32  redirect target
- i_irq_flag  in  1  IRQ entry request
- o_irq_flag  out  1  registered copy of i_irq_flag, updated only when en=1
- o_imem_req_valid  out  1  fetch request valid
- i_imem_req_ready  in  1  memory accepts request
- o_imem_addr  out  32  fetch address, word aligned
- i_imem_rsp_valid  in  1  response valid; in order, no backpressure, at least 1 cycle after accept
- i_imem_rsp_data  in  32  instruction word
- o_inst_valid  out  1  instruction available to decode
- o_inst  out  32  instruction word (queue head)
- o_inst_pc  out  32  address of o_inst
- i_inst_ready  in  1  decode consumes head

Behaviour:
- Reset values:
  - fetch_pc and resp_pc = RESET_VEC.
  - queue count, outstanding and drop_cnt = 0.
  - o_irq_flag = 0; o_imem_req_valid = 0; o_inst_valid = 0.
- Flow control: free = (count + outstanding < DEPTH).
- Request issue:
  - o_imem_req_valid = en & free & ~i_redirect_en & ~i_irq_flag.
  - o_imem_addr = fetch_pc.
  - On accept (valid & ready): outstanding+1 and fetch_pc+4, 32-bit wrap (0xFFFF_FFFC to 0).
- Response handling (always captured, independent of en):
  - drop_cnt>0: discard the word, drop_cnt−1, outstanding−1.
  - Otherwise: push {data, resp_pc}, resp_pc+4, outstanding−1.
  - Overflow is impossible by construction; an assertion checks that a push never happens while count==DEPTH.
- Decode handshake:
  - o_inst_valid = (count!=0) & ~i_redirect_en & ~i_irq_flag.
  - Pop when o_inst_valid & i_inst_ready & en.
  - o_inst/o_inst_pc are the head entry; their value is don't-care while o_inst_valid=0.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (en=1, i_irq_flag or i_redirect_en):
  - Target priority: IRQ_VEC if i_irq_flag, else i_redirect_pc.
  - Next cycle: fetch_pc = resp_pc = target; queue cleared; no request issued in the redirect cycle.
  - drop_cnt = outstanding after this cycle's updates, counting the existing drop_cnt: it becomes old outstanding minus any response arriving this cycle, plus 0 (no issue).
  - First live response after a redirect is tagged with the target address.
- en=0:
  - No issue, pop or redirect; fetch_pc and the queue hold.
  - Responses still push or drop.
  - o_irq_flag holds.
- Simultaneous events:
  - IRQ wins over redirect.
  - Redirect wins over issue and pop.
  - A response in the redirect cycle is discarded and not queued.
- Reset mid-operation: all state clears immediately. Responses to pre-reset requests are an environment error; the memory interface is reset by the same rst_n.
- Latency: accept-to-o_inst_valid = memory latency + 1 cycle (queue registered).

Decomposition:
- Shared core package holds:
  - vector constants RESET_VEC and IRQ_VEC, shared with the exception logic;
  - the fetch-entry typedef {inst[31:0], pc[31:0]}.
- One sub-module: ifetch_queue, a DEPTH-entry synchronous FIFO with clear, push, pop and count.
- The +4 increment reuses the existing adder32.

Test Plan:
- Reset, 1-cycle memory, ready=1 always -> addresses 0x0, 0x4, 0x8…; o_inst_pc tracks; first o_inst_valid 2 cycles after first accept.
- i_inst_ready=0 for 10 cycles -> at most DEPTH requests outstanding+queued, req_valid drops; release -> in-order delivery, no loss or duplication.
- Two requests (0x10, 0x14) outstanding, i_redirect_en with pc 0x200 -> both responses dropped; next o_inst_pc=0x200 carrying the 0x200 word.
- i_irq_flag and i_redirect_en (0x300) in the same cycle -> fetch resumes at 0x4; o_irq_flag=1 the following cycle.
- en=0 for 5 cycles with one response arriving -> no new request, no pop, response queued; after en=1 it is delivered first.
- rst_n asserted mid-stream with a full queue -> outputs immediately 0, the next request after release is to 0x0.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared core package: reset/IRQ vectors and the fetch entry type.
// Used by ifetch_unit, ifetch_queue and the exception logic.
package ifetch_unit_pkg;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h0000_0004;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/adder32.sv
// 32-bit adder, wraps modulo 2^32.
// Ports: a, b in; sum out.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/ifetch_queue.sv
// Prefetch FIFO of fetch entries with clear, push, pop, count.
// Ports: clk, rst_n, clear, push, din, pop; head, count out.
module ifetch_queue
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  fetch_entry_t               din,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue is capped by count + outstanding, so a full queue
  // can never see a live response.
  always @(posedge clk) begin
    if (rst_n && !clear && push) begin
      no_overflow: assert (count != FULL);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: issues imem requests, queues words, feeds decode.
// Ports: en, redirect/irq in, imem req/rsp, inst/pc valid/ready out.
module ifetch_unit #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] RESET_VEC = ifetch_unit_pkg::RESET_VEC,
  parameter logic [31:0] IRQ_VEC   = ifetch_unit_pkg::IRQ_VEC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        i_redirect_en,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_irq_flag,
  output logic        o_irq_flag,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready
);

  import ifetch_unit_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   fetch_pc_inc;
  logic [31:0]   resp_pc_inc;
  logic [31:0]   target;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nx;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   inflight;
  logic          free;
  logic          redir;
  logic          accept;
  logic          dropping;
  logic          push;
  logic          pop;
  fetch_entry_t  push_ent;
  fetch_entry_t  head;

  adder32 u_fetch_inc (
    .a   (fetch_pc),
    .b   (32'd4),
    .sum (fetch_pc_inc)
  );

  adder32 u_resp_inc (
    .a   (resp_pc),
    .b   (32'd4),
    .sum (resp_pc_inc)
  );

  assign inflight = {1'b0, count} + {1'b0, outstanding};
  assign free     = inflight < CAP;
  assign redir    = en & (i_irq_flag | i_redirect_en);
  assign target   = i_irq_flag ? IRQ_VEC : i_redirect_pc;

  // Gated by rst_n so the request is low the instant reset hits.
  assign o_imem_req_valid = rst_n & en & free
                          & ~i_redirect_en & ~i_irq_flag;
  assign o_imem_addr      = fetch_pc;
  assign accept = o_imem_req_valid & i_imem_req_ready;

  assign dropping = drop_cnt != '0;
  assign push     = i_imem_rsp_valid & ~dropping & ~redir;
  assign push_ent = '{inst: i_imem_rsp_data, pc: resp_pc};

  assign o_inst_valid = (count != '0) & ~i_redirect_en & ~i_irq_flag;
  assign pop          = o_inst_valid & i_inst_ready & en;
  assign o_inst       = head.inst;
  assign o_inst_pc    = head.pc;

  assign outstanding_nx = outstanding + CW'(accept)
                        - CW'(i_imem_rsp_valid);

  ifetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redir),
    .push  (push),
    .din   (push_ent),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_VEC;
      resp_pc     <= RESET_VEC;
      outstanding <= '0;
      drop_cnt    <= '0;
      o_irq_flag  <= 1'b0;
    end else begin
      outstanding <= outstanding_nx;
      if (redir) begin
        // Everything still in flight belongs to the old stream.
        fetch_pc <= target;
        resp_pc  <= target;
        drop_cnt <= outstanding_nx;
      end else begin
        if (accept) fetch_pc <= fetch_pc_inc;
        if (push) resp_pc <= resp_pc_inc;
        if (i_imem_rsp_valid && dropping) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
      end
      if (en) o_irq_flag <= i_irq_flag;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit with a variable-latency imem model.
// Directed phases; monitor pops expected {inst, pc} on each handoff.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        i_redirect_en = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_irq_flag = 1'b0;
  logic        o_irq_flag;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready = 1'b0;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid = 1'b0;
  logic [31:0] i_imem_rsp_data = '0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready = 1'b0;

  ifetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en               (en),
    .i_redirect_en    (i_redirect_en),
    .i_redirect_pc    (i_redirect_pc),
    .i_irq_flag       (i_irq_flag),
    .o_irq_flag       (o_irq_flag),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .i_inst_ready     (i_inst_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int lat = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend [$];
  pend_t       cur;
  logic [63:0] exp_q [$];
  logic [63:0] e;

  // Memory model: word = addr ^ CAFE_0000, returned lat cycles later.
  always @(negedge clk) begin
    if (rst_n && o_imem_req_valid && i_imem_req_ready) begin
      pend.push_back('{o_imem_addr, cyc + lat});
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    if (!rst_n) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      cur = pend.pop_front();
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = cur.addr ^ 32'hCAFE_0000;
    end
  end

  // Monitor: every decode handoff is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && en && o_inst_valid && i_inst_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL deliver: got pc %h inst %h, want nothing",
                 o_inst_pc, o_inst);
      end else begin
        e = exp_q.pop_front();
        if ({o_inst, o_inst_pc} === e) passes++;
        else $display("FAIL deliver: got pc %h inst %h, want pc %h inst %h",
                      o_inst_pc, o_inst, e[31:0], e[63:32]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act,
                      input logic want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %b want %b", name, act, want);
  endtask

  task automatic chk32(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endtask

  task automatic exp_item(input logic [31:0] inst,
                          input logic [31:0] pc);
    exp_q.push_back({inst, pc});
  endtask

  task automatic drain(input string name);
    i_inst_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL %s: %0d entries undelivered, want 0",
                  name, exp_q.size());
    exp_q.delete();
    i_inst_ready = 1'b0;
  endtask

  int  n;
  logic seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    en = 1'b1;
    i_imem_req_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk1("rst_req_valid", o_imem_req_valid, 1'b0);
    chk1("rst_inst_valid", o_inst_valid, 1'b0);
    chk1("rst_irq_flag", o_irq_flag, 1'b0);

    // Phase 1: first fetch from 0x0, 2-cycle accept-to-valid.
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("first_req_valid", o_imem_req_valid, 1'b1);
    chk32("first_addr", o_imem_addr, 32'h0);
    @(negedge clk);
    chk1("lat_cycle1_valid", o_inst_valid, 1'b0);
    @(negedge clk);
    chk1("lat_cycle2_valid", o_inst_valid, 1'b1);
    tick();
    exp_item(32'hCAFE_0000, 32'h00);
    exp_item(32'hCAFE_0004, 32'h04);
    exp_item(32'hCAFE_0008, 32'h08);
    exp_item(32'hCAFE_000C, 32'h0C);
    exp_item(32'hCAFE_0010, 32'h10);
    exp_item(32'hCAFE_0014, 32'h14);
    drain("stream_drain");

    // Phase 2: decode stalled, issue must stop at the cap.
    repeat (3) tick();
    n = 0;
    repeat (7) begin
      @(negedge clk);
      if (o_imem_req_valid) n++;
    end
    chk32("stall_no_req", n, 0);
    chk1("stall_queue_valid", o_inst_valid, 1'b1);
    tick();
    exp_item(32'hCAFE_0018, 32'h18);
    exp_item(32'hCAFE_001C, 32'h1C);
    exp_item(32'hCAFE_0020, 32'h20);
    exp_item(32'hCAFE_0024, 32'h24);
    exp_item(32'hCAFE_0028, 32'h28);
    exp_item(32'hCAFE_002C, 32'h2C);
    drain("stall_drain");

    // Phase 3: two requests in flight, redirect to 0x200.
    repeat (4) tick();
    lat = 3;
    i_redirect_pc = 32'h10;
    i_redirect_en = 1'b1;
    tick();
    i_redirect_en = 1'b0;
    @(negedge clk);
    chk1("redir_req0_valid", o_imem_req_valid, 1'b1);
    chk32("redir_req0_addr", o_imem_addr, 32'h10);
    tick();
    @(negedge clk);
    chk1("redir_req1_valid", o_imem_req_valid, 1'b1);
    chk32("redir_req1_addr", o_imem_addr, 32'h14);
    tick();
    exp_item(32'hCAFE_0200, 32'h200);
    exp_item(32'hCAFE_0204, 32'h204);
    exp_item(32'hCAFE_0208, 32'h208);
    i_redirect_pc = 32'h200;
    i_redirect_en = 1'b1;
    @(negedge clk);
    chk1("redir_cycle_no_req", o_imem_req_valid, 1'b0);
    tick();
    i_redirect_en = 1'b0;
    drain("redir_drain");

    // Phase 4: IRQ and redirect together, IRQ wins.
    lat = 1;
    repeat (6) tick();
    exp_item(32'hCAFE_0004, 32'h04);
    exp_item(32'hCAFE_0008, 32'h08);
    i_irq_flag = 1'b1;
    i_redirect_en = 1'b1;
    i_redirect_pc = 32'h300;
    tick();
    i_irq_flag = 1'b0;
    i_redirect_en = 1'b0;
    @(negedge clk);
    chk1("irq_flag_set", o_irq_flag, 1'b1);
    chk1("irq_req_valid", o_imem_req_valid, 1'b1);
    chk32("irq_req_addr", o_imem_addr, 32'h4);
    tick();
    drain("irq_drain");
    chk1("irq_flag_clear", o_irq_flag, 1'b0);

    // Phase 5: en low while a response lands.
    repeat (6) tick();
    lat = 3;
    exp_item(32'hCAFE_0400, 32'h400);
    exp_item(32'hCAFE_0404, 32'h404);
    exp_item(32'hCAFE_0408, 32'h408);
    i_redirect_pc = 32'h400;
    i_redirect_en = 1'b1;
    tick();
    i_redirect_en = 1'b0;
    @(negedge clk);
    chk32("en_req_addr", o_imem_addr, 32'h400);
    tick();
    en = 1'b0;
    i_inst_ready = 1'b1;
    n = 0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (o_imem_req_valid) n++;
      if (o_inst_valid) seen = 1'b1;
      tick();
    end
    chk32("en_low_no_req", n, 0);
    chk1("en_low_rsp_queued", seen, 1'b1);
    en = 1'b1;
    drain("en_drain");

    // Phase 6: reset with a full queue.
    lat = 1;
    repeat (6) tick();
    @(negedge clk);
    chk1("pre_rst_full", o_inst_valid, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_inst_valid", o_inst_valid, 1'b0);
    chk1("mid_rst_req_valid", o_imem_req_valid, 1'b0);
    tick();
    tick();
    exp_item(32'hCAFE_0000, 32'h00);
    exp_item(32'hCAFE_0004, 32'h04);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post_rst_req_valid", o_imem_req_valid, 1'b1);
    chk32("post_rst_addr", o_imem_addr, 32'h0);
    tick();
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
